sparse_compactor: RTL and testbench
===================================

Name: sparse_compactor

Overview:
- Parametrised stream-compaction engine. Accepts an N-element signed fixed-point vector and emits its significant elements packed to the low indices, in original order.
- Also emits each kept element's source index and the kept count (nnz).
- An element is significant when its magnitude exceeds a per-vector threshold; threshold 0 gives exact-zero removal.
- Sits between the image-update stage and the sparse MAC stage. Scans LANES elements per cycle.

Parameters:
- IL, 8, integer bits of fixed-point element
- FL, 12, fraction bits of fixed-point element
- N, 16, vector length; power of two, >=2
- LANES, 1, elements examined per SCAN cycle; power of two, divides N
- W (localparam), IL+FL, element width
- IDXW (localparam), $clog2(N), index width
- CNTW (localparam), $clog2(N+1), count width

Ports:
- clk  in  1  clock
- reset  in  1  reset
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept a vector
- in_vec  in  N x W signed  input vector
- threshold  in  W unsigned  keep threshold on magnitude; sampled with in_vec
- out_valid  out  1  compacted result valid
- out_ready  in  1  downstream accepts result
- out_vec  out  N x W signed  compacted values
- out_idx  out  N x IDXW  source index of each out_vec slot
- out_nnz  out  CNTW  number of kept elements, 0..N
- state  out  2  FSM state, for debug

Behaviour:
- Clock clk; reset reset, synchronous, active-high.
- Reset values:
  - state=IDLE, out_vec/out_idx all 0, out_nnz=0, out_valid=0.
  - Internal captured vector, threshold and pointers all 0.
- States: IDLE=2'b00, SCAN=2'b01, DONE=2'b10. Encoding 2'b11 is unreachable and recovers to IDLE on the next edge.
- in_ready=1 only in IDLE. out_valid=1 only in DONE. Both are decoded from state.
- IDLE:
  - On in_valid&&in_ready, capture in_vec and threshold into registers.
  - Clear out_vec, out_idx, out_nnz, i_ptr and o_ptr to 0, then go to SCAN.
  - in_vec is not read after capture; the source may change freely.
- SCAN, each cycle:
  - Examine captured elements i_ptr .. i_ptr+LANES-1.
  - keep[k] = |x| > threshold. Compare magnitude in W+1 bits; the most negative value has magnitude 2^(W-1) and no wrap.
  - Each kept element goes to slot o_ptr + (number of kept lanes below k). Its out_idx is its source index.
  - i_ptr += LANES; o_ptr += popcount(keep).
  - After the cycle that examines element N-1, go to DONE. out_nnz = final o_ptr, and it is written in that same cycle.
- Latency: handshake edge, then N/LANES SCAN cycles. out_valid rises exactly N/LANES+1 cycles after the input handshake edge.
- DONE:
  - Outputs hold stable while out_valid && !out_ready.
  - On out_ready, go to IDLE. Outputs keep their values until the next capture.
- Unused slots (index >= out_nnz) are 0 in both out_vec and out_idx.
- out_ready outside DONE is ignored. in_valid outside IDLE is ignored and not queued.
- Back-to-back: minimum input spacing is N/LANES+2 cycles; IDLE lasts at least one cycle.
- Order is preserved; no duplicates. o_ptr never exceeds N (CNTW holds N).
- Reset mid-SCAN or mid-DONE: state returns to IDLE and all outputs clear on that edge. No partial result is presented.

Decomposition:
- Shared package sparse_pkg:
  - typedef enum logic [1:0] sparse_state_t {IDLE, SCAN, DONE}
  - function abs_mag(x), returning W+1 bit unsigned
  - fixed-point width constants IL and FL, shared with the sibling update blocks
- Sub-module lane_keep_prefix, combinational:
  - inputs: LANES elements and threshold
  - outputs: keep mask, exclusive prefix counts, popcount
  - instanced once; keeps the top-level FSM and write logic compact

Test Plan:
1. N=16, LANES=1, thr=0, in_vec=[0,4096,0,0,-8192,0…0,12288 at idx15] -> out_valid 17 cycles after handshake; out_vec=[4096,-8192,12288,0…]; out_idx=[1,4,15,0…]; out_nnz=3.
2. thr=2048, in_vec idx0..3=[2048,-2049,1000,-524288(min)], rest 0 -> kept -2049 and -524288; out_idx=[1,3]; out_nnz=2 (equality dropped, min value kept).
3. LANES=4, all 16 elements =-1 with thr=0 -> out_vec = in_vec; out_idx=0..15; out_nnz=16; out_valid 5 cycles after handshake.
4. All zeros -> out_nnz=0, all slots 0; then hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0; in_valid pulses during SCAN/DONE are ignored.
5. Assert reset on the 6th SCAN cycle -> next cycle state=IDLE, out_valid=0, outputs 0. A new vector then processes correctly.
6. Change in_vec every cycle after the handshake -> result reflects only the captured vector.

Source files
------------

// File: rtl/sparse_compactor_pkg.sv
// Shared types and helpers for the sparse compaction path.
// Fixed-point widths are common with the sibling update blocks.
package sparse_pkg;

  localparam int IL   = 8;
  localparam int FL   = 12;
  localparam int MAXW = 64;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } sparse_state_t;

  // Magnitude of a sign-extended value; one extra bit so the
  // most negative input does not wrap.
  function automatic logic [MAXW:0] abs_mag(
    input logic [MAXW-1:0] x
  );
    logic [MAXW:0] e;
    e = {x[MAXW-1], x};
    return x[MAXW-1] ? (~e + {{MAXW{1'b0}}, 1'b1}) : e;
  endfunction

endpackage

// File: rtl/sparse_compactor_lane_keep_prefix.sv
// Per-lane keep decision with exclusive prefix counts and popcount.
// Purely combinational; one instance serves all scan lanes.
module lane_keep_prefix
  import sparse_pkg::*;
#(
  parameter int W     = 20,
  parameter int LANES = 1,
  parameter int PW    = 4,
  parameter int CW    = 5
) (
  input  logic [LANES*W-1:0]  i_x,
  input  logic [W-1:0]        i_thr,
  output logic [LANES-1:0]    o_keep,
  output logic [LANES*PW-1:0] o_pfx,
  output logic [CW-1:0]       o_cnt
);

  logic [MAXW:0] w_thr;
  logic [CW-1:0] w_acc;

  assign w_thr = {{(MAXW+1-W){1'b0}}, i_thr};

  always_comb begin
    w_acc  = '0;
    o_keep = '0;
    o_pfx  = '0;
    for (int k = 0; k < LANES; k++) begin
      o_keep[k] = abs_mag({{(MAXW-W){i_x[k*W+W-1]}},
                           i_x[k*W +: W]}) > w_thr;
      o_pfx[k*PW +: PW] = w_acc[PW-1:0];
      w_acc = w_acc + {{(CW-1){1'b0}}, o_keep[k]};
    end
  end

  assign o_cnt = w_acc;

endmodule

// File: rtl/sparse_compactor.sv
// Stream compactor: packs elements whose magnitude exceeds a
// threshold to the low slots, with source indices and count.
module sparse_compactor #(
  parameter int IL    = sparse_pkg::IL,
  parameter int FL    = sparse_pkg::FL,
  parameter int N     = 16,
  parameter int LANES = 1,
  localparam int W    = IL + FL,
  localparam int IDXW = $clog2(N),
  localparam int CNTW = $clog2(N + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*W-1:0]    in_vec,
  input  logic [W-1:0]      threshold,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*W-1:0]    out_vec,
  output logic [N*IDXW-1:0] out_idx,
  output logic [CNTW-1:0]   out_nnz,
  output logic [1:0]        state
);

  import sparse_pkg::*;

  sparse_state_t r_state;
  sparse_state_t w_next;

  logic [W-1:0]    r_vec  [N];
  logic [W-1:0]    r_ovec [N];
  logic [IDXW-1:0] r_oidx [N];
  logic [W-1:0]    r_thr;
  logic [IDXW-1:0] r_iptr;
  logic [CNTW-1:0] r_optr;
  logic [CNTW-1:0] r_nnz;

  logic [LANES*W-1:0]    w_lx;
  logic [LANES-1:0]      w_keep;
  logic [LANES*IDXW-1:0] w_pfx;
  logic [CNTW-1:0]       w_cnt;
  logic [IDXW-1:0]       w_slot [LANES];
  logic                  w_last;
  logic                  w_take;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign state     = r_state;
  assign out_nnz   = r_nnz;
  assign w_take    = in_valid && (r_state == IDLE);
  assign w_last    = (r_iptr == IDXW'(N - LANES));

  for (genvar g = 0; g < N; g++) begin : g_out
    assign out_vec[g*W +: W]       = r_ovec[g];
    assign out_idx[g*IDXW +: IDXW] = r_oidx[g];
  end

  always_comb begin
    w_lx = '0;
    for (int k = 0; k < LANES; k++) begin
      w_lx[k*W +: W] = r_vec[r_iptr + IDXW'(k)];
    end
  end

  lane_keep_prefix #(
    .W     (W),
    .LANES (LANES),
    .PW    (IDXW),
    .CW    (CNTW)
  ) u_keep (
    .i_x    (w_lx),
    .i_thr  (r_thr),
    .o_keep (w_keep),
    .o_pfx  (w_pfx),
    .o_cnt  (w_cnt)
  );

  // A kept lane's slot is always < N, so the low bits suffice.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_slot[k] = r_optr[IDXW-1:0] + w_pfx[k*IDXW +: IDXW];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = w_take ? SCAN : IDLE;
      SCAN:    w_next = w_last ? DONE : SCAN;
      DONE:    w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_thr  <= '0;
      r_iptr <= '0;
      r_optr <= '0;
      r_nnz  <= '0;
      for (int i = 0; i < N; i++) begin
        r_vec[i]  <= '0;
        r_ovec[i] <= '0;
        r_oidx[i] <= '0;
      end
    end else if (w_take) begin
      r_thr  <= threshold;
      r_iptr <= '0;
      r_optr <= '0;
      r_nnz  <= '0;
      for (int i = 0; i < N; i++) begin
        r_vec[i]  <= in_vec[i*W +: W];
        r_ovec[i] <= '0;
        r_oidx[i] <= '0;
      end
    end else if (r_state == SCAN) begin
      for (int k = 0; k < LANES; k++) begin
        if (w_keep[k]) begin
          r_ovec[w_slot[k]] <= w_lx[k*W +: W];
          r_oidx[w_slot[k]] <= r_iptr + IDXW'(k);
        end
      end
      r_iptr <= r_iptr + IDXW'(LANES);
      r_optr <= r_optr + w_cnt;
      if (w_last) r_nnz <= r_optr + w_cnt;
    end
  end

endmodule

// File: tb/tb_sparse_compactor.sv
// Directed bench for sparse_compactor: one LANES=1 and one
// LANES=4 instance share clock and reset.
module tb_sparse_compactor;

  localparam int N    = 16;
  localparam int W    = 20;
  localparam int IDXW = 4;
  localparam int CNTW = 5;
  localparam int BW   = N * W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              a_iv, a_ir, a_ov, a_or;
  logic [N*W-1:0]    a_vec, a_ovec;
  logic [W-1:0]      a_thr;
  logic [N*IDXW-1:0] a_oidx;
  logic [CNTW-1:0]   a_nnz;
  logic [1:0]        a_st;

  logic              b_iv, b_ir, b_ov, b_or;
  logic [N*W-1:0]    b_vec, b_ovec;
  logic [W-1:0]      b_thr;
  logic [N*IDXW-1:0] b_oidx;
  logic [CNTW-1:0]   b_nnz;
  logic [1:0]        b_st;

  int ntot = 0;
  int nfail = 0;

  logic [N*W-1:0]    ev;
  logic [N*IDXW-1:0] ei;
  int                lat;

  sparse_compactor #(.N(N), .LANES(1)) u_a (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (a_iv),
    .in_ready  (a_ir),
    .in_vec    (a_vec),
    .threshold (a_thr),
    .out_valid (a_ov),
    .out_ready (a_or),
    .out_vec   (a_ovec),
    .out_idx   (a_oidx),
    .out_nnz   (a_nnz),
    .state     (a_st)
  );

  sparse_compactor #(.N(N), .LANES(4)) u_b (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (b_iv),
    .in_ready  (b_ir),
    .in_vec    (b_vec),
    .threshold (b_thr),
    .out_valid (b_ov),
    .out_ready (b_or),
    .out_vec   (b_ovec),
    .out_idx   (b_oidx),
    .out_nnz   (b_nnz),
    .state     (b_st)
  );

  task automatic chk(input string tag,
                     input logic [BW-1:0] obs,
                     input logic [BW-1:0] exp);
    ntot++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] setv(
    input logic [N*W-1:0] v, input int i, input int x);
    v[i*W +: W] = W'(x);
    return v;
  endfunction

  function automatic logic [N*IDXW-1:0] seti(
    input logic [N*IDXW-1:0] v, input int i, input int x);
    v[i*IDXW +: IDXW] = IDXW'(x);
    return v;
  endfunction

  task automatic run_a(output int l);
    a_iv = 1'b1;
    tick();
    a_iv = 1'b0;
    l = 1;
    while (!a_ov && l < 40) begin
      tick();
      l++;
    end
  endtask

  task automatic run_b(output int l);
    b_iv = 1'b1;
    tick();
    b_iv = 1'b0;
    l = 1;
    while (!b_ov && l < 40) begin
      tick();
      l++;
    end
  endtask

  initial begin
    a_iv = 0; a_or = 1; a_vec = '0; a_thr = '0;
    b_iv = 0; b_or = 1; b_vec = '0; b_thr = '0;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_state", a_st, 0);
    chk("rst_ovalid", a_ov, 0);
    chk("rst_iready", a_ir, 1);
    chk("rst_nnz", a_nnz, 0);
    chk("rst_ovec", a_ovec, 0);
    chk("rst_oidx", a_oidx, 0);
    chk("rst_b_state", b_st, 0);
    reset = 1'b0;

    // T1: exact-zero removal
    a_vec = '0;
    a_vec = setv(a_vec, 1, 4096);
    a_vec = setv(a_vec, 4, -8192);
    a_vec = setv(a_vec, 15, 12288);
    a_thr = '0;
    run_a(lat);
    ev = '0; ev = setv(ev, 0, 4096);
    ev = setv(ev, 1, -8192); ev = setv(ev, 2, 12288);
    ei = '0; ei = seti(ei, 0, 1);
    ei = seti(ei, 1, 4); ei = seti(ei, 2, 15);
    chk("t1_lat", lat, 17);
    chk("t1_vec", a_ovec, ev);
    chk("t1_idx", a_oidx, ei);
    chk("t1_nnz", a_nnz, 3);
    chk("t1_iready", a_ir, 0);
    tick();
    chk("t1_idle", a_st, 0);
    chk("t1_hold_nnz", a_nnz, 3);
    chk("t1_hold_vec", a_ovec, ev);

    // T2: threshold equality dropped, min value kept
    a_vec = '0;
    a_vec = setv(a_vec, 0, 2048);
    a_vec = setv(a_vec, 1, -2049);
    a_vec = setv(a_vec, 2, 1000);
    a_vec = setv(a_vec, 3, -524288);
    a_thr = W'(2048);
    run_a(lat);
    ev = '0; ev = setv(ev, 0, -2049);
    ev = setv(ev, 1, -524288);
    ei = '0; ei = seti(ei, 0, 1); ei = seti(ei, 1, 3);
    chk("t2_lat", lat, 17);
    chk("t2_vec", a_ovec, ev);
    chk("t2_idx", a_oidx, ei);
    chk("t2_nnz", a_nnz, 2);
    tick();

    // T3: LANES=4, all -1
    b_vec = '1;
    b_thr = '0;
    run_b(lat);
    ei = '0;
    for (int i = 0; i < N; i++) ei = seti(ei, i, i);
    chk("t3_lat", lat, 5);
    chk("t3_vec", b_ovec, {BW{1'b1}});
    chk("t3_idx", b_oidx, ei);
    chk("t3_nnz", b_nnz, 16);
    tick();
    chk("t3_idle", b_st, 0);

    // T4: all zeros, backpressure, ignored in_valid
    a_or = 1'b0;
    a_vec = '0;
    a_thr = '0;
    a_iv = 1'b1;
    tick();
    a_iv = 1'b0;
    tick();
    tick();
    chk("t4_scan_state", a_st, 1);
    chk("t4_scan_iready", a_ir, 0);
    a_vec = setv(a_vec, 5, 777);
    a_iv = 1'b1;
    tick();
    a_iv = 1'b0;
    lat = 0;
    while (!a_ov && lat < 40) begin
      tick();
      lat++;
    end
    chk("t4_done", a_ov, 1);
    chk("t4_vec", a_ovec, 0);
    chk("t4_idx", a_oidx, 0);
    chk("t4_nnz", a_nnz, 0);
    for (int i = 0; i < 10; i++) begin
      a_iv = (i == 3);
      tick();
      chk("t4_hold_state", a_st, 2);
      chk("t4_hold_iready", a_ir, 0);
    end
    a_iv = 1'b0;
    chk("t4_hold_vec", a_ovec, 0);
    chk("t4_hold_nnz", a_nnz, 0);
    a_or = 1'b1;
    tick();
    chk("t4_release", a_st, 0);
    tick();
    chk("t4_not_queued", a_st, 0);

    // T5: reset in the 6th SCAN cycle
    a_vec = '0;
    a_vec = setv(a_vec, 1, 4096);
    a_vec = setv(a_vec, 4, -8192);
    a_thr = '0;
    a_iv = 1'b1;
    tick();
    a_iv = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t5_pre_state", a_st, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_state", a_st, 0);
    chk("t5_ovalid", a_ov, 0);
    chk("t5_vec", a_ovec, 0);
    chk("t5_idx", a_oidx, 0);
    chk("t5_nnz", a_nnz, 0);
    a_vec = '0;
    a_vec = setv(a_vec, 7, -101);
    a_vec = setv(a_vec, 8, 101);
    a_vec = setv(a_vec, 9, 100);
    a_thr = W'(100);
    run_a(lat);
    ev = '0; ev = setv(ev, 0, -101); ev = setv(ev, 1, 101);
    ei = '0; ei = seti(ei, 0, 7); ei = seti(ei, 1, 8);
    chk("t5_new_lat", lat, 17);
    chk("t5_new_vec", a_ovec, ev);
    chk("t5_new_idx", a_oidx, ei);
    chk("t5_new_nnz", a_nnz, 2);
    tick();

    // T6: source changes after capture
    a_vec = '0;
    a_vec = setv(a_vec, 0, 5);
    a_vec = setv(a_vec, 15, -5);
    a_thr = '0;
    a_iv = 1'b1;
    tick();
    a_iv = 1'b0;
    lat = 1;
    while (!a_ov && lat < 40) begin
      a_vec = {10{$urandom()}};
      a_thr = W'($urandom());
      tick();
      lat++;
    end
    ev = '0; ev = setv(ev, 0, 5); ev = setv(ev, 1, -5);
    ei = '0; ei = seti(ei, 0, 0); ei = seti(ei, 1, 15);
    chk("t6_lat", lat, 17);
    chk("t6_vec", a_ovec, ev);
    chk("t6_idx", a_oidx, ei);
    chk("t6_nnz", a_nnz, 2);

    $display("%0d/%0d checks passed", ntot - nfail, ntot);
    $finish;
  end

endmodule
